// File: rtl/if_fetch_unit.sv
// IF stage of the simplemips pipeline: owns the PC, fetches over a req/ack handshake and
// presents {pc, inst, valid} to IF_ID with bubbles, stall hold, a skid entry and delayed branches.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o
);

  // state | meaning
  // START | first edge after reset release, no request yet
  // REQ   | request outstanding at r_pc
  // HOLD  | acked instruction parked in skid while output is stalled; no request
  // FLUSH | wrong-path request in flight at r_flush_addr; its data is dropped
  typedef enum logic [1:0] {START, REQ, HOLD, FLUSH} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_flush_addr, w_flush_addr_nxt;
  logic [31:0] r_redirect_pc, w_redirect_pc_nxt;
  logic        r_pending, w_pending_nxt;
  logic [31:0] r_skid_pc, w_skid_pc_nxt;
  logic [31:0] r_skid_inst, w_skid_inst_nxt;
  logic [31:0] r_out_pc, w_out_pc_nxt;
  logic [31:0] r_out_inst, w_out_inst_nxt;
  logic        r_out_valid, w_out_valid_nxt;
  logic        w_slot_free;
  logic        w_branch;
  logic [31:0] w_pc_inc;

  assign w_slot_free = !r_out_valid || !stall_i;
  // a branch inside a delay slot is undefined, so it is simply not accepted
  assign w_branch    = branch_flag_i && !r_pending && (r_state != FLUSH);
  assign w_pc_inc    = r_pc + 32'd4;

  assign imem_req_o  = (r_state == REQ) || (r_state == FLUSH);
  assign imem_addr_o = (r_state == FLUSH) ? r_flush_addr : r_pc;
  assign if_pc_o     = r_out_pc;
  assign if_inst_o   = r_out_inst;
  assign if_valid_o  = r_out_valid;

  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_flush_addr_nxt  = r_flush_addr;
    w_redirect_pc_nxt = r_redirect_pc;
    w_pending_nxt     = r_pending;
    w_skid_pc_nxt     = r_skid_pc;
    w_skid_inst_nxt   = r_skid_inst;
    w_out_pc_nxt      = r_out_pc;
    w_out_inst_nxt    = r_out_inst;
    w_out_valid_nxt   = r_out_valid;

    if (w_slot_free) begin
      w_out_inst_nxt  = '0;
      w_out_valid_nxt = 1'b0;
    end

    case (r_state)
      START: begin
        w_state_nxt = REQ;
        if (w_branch) begin
          w_redirect_pc_nxt = branch_target_i;
          w_pending_nxt     = 1'b1;
        end
      end
      REQ: begin
        if (imem_ack_i) begin
          if (w_branch && r_out_valid) begin
            w_pc_nxt = branch_target_i;
          end else begin
            if (w_slot_free) begin
              w_out_pc_nxt    = r_pc;
              w_out_inst_nxt  = imem_rdata_i;
              w_out_valid_nxt = 1'b1;
            end else begin
              w_skid_pc_nxt   = r_pc;
              w_skid_inst_nxt = imem_rdata_i;
              w_state_nxt     = HOLD;
            end
            // the instruction just taken is a delay slot if a redirect is due
            if (w_branch) begin
              w_pc_nxt = branch_target_i;
            end else if (r_pending) begin
              w_pc_nxt      = r_redirect_pc;
              w_pending_nxt = 1'b0;
            end else begin
              w_pc_nxt = w_pc_inc;
            end
          end
        end else if (w_branch) begin
          if (r_out_valid) begin
            w_pc_nxt         = branch_target_i;
            w_flush_addr_nxt = r_pc;
            w_state_nxt      = FLUSH;
          end else begin
            w_redirect_pc_nxt = branch_target_i;
            w_pending_nxt     = 1'b1;
          end
        end
      end
      HOLD: begin
        if (w_branch) begin
          w_pc_nxt        = branch_target_i;
          w_skid_pc_nxt   = '0;
          w_skid_inst_nxt = '0;
          w_state_nxt     = REQ;
        end else if (!stall_i) begin
          w_out_pc_nxt    = r_skid_pc;
          w_out_inst_nxt  = r_skid_inst;
          w_out_valid_nxt = 1'b1;
          w_skid_pc_nxt   = '0;
          w_skid_inst_nxt = '0;
          w_state_nxt     = REQ;
        end
      end
      FLUSH: begin
        if (imem_ack_i) w_state_nxt = REQ;
      end
      default: w_state_nxt = START;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= START;
      r_pc          <= RESET_PC;
      r_flush_addr  <= '0;
      r_redirect_pc <= '0;
      r_pending     <= 1'b0;
      r_skid_pc     <= '0;
      r_skid_inst   <= '0;
      r_out_pc      <= '0;
      r_out_inst    <= '0;
      r_out_valid   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_flush_addr  <= w_flush_addr_nxt;
      r_redirect_pc <= w_redirect_pc_nxt;
      r_pending     <= w_pending_nxt;
      r_skid_pc     <= w_skid_pc_nxt;
      r_skid_inst   <= w_skid_inst_nxt;
      r_out_pc      <= w_out_pc_nxt;
      r_out_inst    <= w_out_inst_nxt;
      r_out_valid   <= w_out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed pipeline scenarios, then random stall/wait/branch traffic
// checked against an instruction-stream model of delayed-branch MIPS fetch.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ack_i      (imem_ack_i),
    .imem_rdata_i    (imem_rdata_i),
    .if_pc_o         (if_pc_o),
    .if_inst_o       (if_inst_o),
    .if_valid_o      (if_valid_o)
  );

  int checks   = 0;
  int failures = 0;

  // memory model
  bit          mem_busy;
  logic [31:0] mem_addr;
  int          mem_cnt;
  bit          rand_wait;
  bit          slow_en;
  logic [31:0] slow_addr;
  int          slow_wait;

  // values seen just before the latest edge
  logic        pre_valid, pre_stall, pre_branch;
  logic [31:0] pre_pc, pre_inst, pre_tgt;

  // stream model
  logic [31:0] exp_next, slot_tgt;
  bit          slot_wait, tgt_next, armed;
  int          deliveries, idle, max_idle;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                         input logic v);
    check({tag, "_pc"}, if_pc_o, pc);
    check({tag, "_inst"}, if_inst_o, inst);
    check({tag, "_valid"}, {31'b0, if_valid_o}, {31'b0, v});
  endtask

  task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
    check({tag, "_req"}, {31'b0, imem_req_o}, {31'b0, req});
    if (req) check({tag, "_addr"}, imem_addr_o, addr);
  endtask

  function automatic int pick_wait(input logic [31:0] a);
    if (rand_wait) return int'($urandom_range(0, 2));
    if (slow_en && a == slow_addr) return slow_wait;
    return 0;
  endfunction

  // called just after each edge: decides ack/rdata for the coming cycle
  task automatic mem_update();
    if (imem_ack_i) mem_busy = 1'b0;
    imem_ack_i   = 1'b0;
    imem_rdata_i = $urandom;
    if (!imem_req_o) begin
      mem_busy = 1'b0;
    end else begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_addr = imem_addr_o;
        mem_cnt  = pick_wait(imem_addr_o);
      end else begin
        check("mem_addr_stable", imem_addr_o, mem_addr);
      end
      if (mem_cnt == 0) begin
        imem_ack_i   = 1'b1;
        imem_rdata_i = inst_of(mem_addr);
      end else begin
        mem_cnt--;
      end
    end
  endtask

  task automatic tick();
    pre_valid  = if_valid_o;
    pre_stall  = stall_i;
    pre_branch = branch_flag_i;
    pre_pc     = if_pc_o;
    pre_inst   = if_inst_o;
    pre_tgt    = branch_target_i;
    @(posedge clk);
    #1;
    mem_update();
  endtask

  // asserts reset away from the edge, checks the async values, releases after two edges
  task automatic do_reset(input string tag);
    rst           = 1'b0;
    stall_i       = 1'b0;
    branch_flag_i = 1'b0;
    imem_ack_i    = 1'b0;
    mem_busy      = 1'b0;
    #1;
    check({tag, "_req"}, {31'b0, imem_req_o}, 32'd0);
    check({tag, "_addr"}, imem_addr_o, 32'h0000_0000);
    chk_out(tag, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst             = 1'b0;
    stall_i         = 1'b0;
    branch_flag_i   = 1'b0;
    branch_target_i = '0;
    imem_ack_i      = 1'b0;
    imem_rdata_i    = '0;
    rand_wait       = 1'b0;
    slow_en         = 1'b0;
    slow_addr       = '0;
    slow_wait       = 0;

    // sequential fetch, zero-wait
    do_reset("rst0");
    tick(); chk_req("s1_e1", 1'b1, 32'h0); chk_out("s1_e1", 32'h0, 32'h0, 1'b0);
    tick(); chk_out("s1_e2", 32'h0, inst_of(32'h0), 1'b1);
    tick(); chk_out("s1_e3", 32'h4, inst_of(32'h4), 1'b1);
    tick(); chk_out("s1_e4", 32'h8, inst_of(32'h8), 1'b1);
    tick(); chk_out("s1_e5", 32'hC, inst_of(32'hC), 1'b1);

    // two wait states at 0x8
    slow_en = 1'b1; slow_addr = 32'h8; slow_wait = 2;
    do_reset("rst1");
    tick(); tick();
    tick(); chk_out("s2_a", 32'h4, inst_of(32'h4), 1'b1); chk_req("s2_a", 1'b1, 32'h8);
    tick(); chk_out("s2_b", 32'h4, 32'h0, 1'b0);           chk_req("s2_b", 1'b1, 32'h8);
    tick(); chk_out("s2_c", 32'h4, 32'h0, 1'b0);           chk_req("s2_c", 1'b1, 32'h8);
    tick(); chk_out("s2_d", 32'h8, inst_of(32'h8), 1'b1);

    // ack lands while stalled -> skid/HOLD
    slow_en = 1'b0;
    do_reset("rst2");
    tick(); tick();
    tick(); chk_out("s3_a", 32'h4, inst_of(32'h4), 1'b1); chk_req("s3_a", 1'b1, 32'h8);
    stall_i = 1'b1;
    tick(); chk_out("s3_b", 32'h4, inst_of(32'h4), 1'b1); chk_req("s3_b", 1'b0, 32'h0);
    tick(); chk_out("s3_c", 32'h4, inst_of(32'h4), 1'b1); chk_req("s3_c", 1'b0, 32'h0);
    stall_i = 1'b0;
    tick(); chk_out("s3_d", 32'h8, inst_of(32'h8), 1'b1); chk_req("s3_d", 1'b1, 32'hC);

    // branch with valid output and request outstanding -> flush
    slow_en = 1'b1; slow_addr = 32'h10; slow_wait = 1;
    tick(); chk_out("s4_a", 32'hC, inst_of(32'hC), 1'b1); chk_req("s4_a", 1'b1, 32'h10);
    branch_flag_i = 1'b1; branch_target_i = 32'h100;
    tick(); branch_flag_i = 1'b0;
    chk_out("s4_b", 32'hC, 32'h0, 1'b0); chk_req("s4_b", 1'b1, 32'h10);
    tick(); chk_out("s4_c", 32'hC, 32'h0, 1'b0); chk_req("s4_c", 1'b1, 32'h100);
    tick(); chk_out("s4_d", 32'h100, inst_of(32'h100), 1'b1);
    tick(); chk_out("s4_e", 32'h104, inst_of(32'h104), 1'b1);

    // branch with bubble output -> next capture is the delay slot
    slow_wait = 2;
    do_reset("rst3");
    tick(); tick(); tick(); tick();
    tick(); chk_out("s5_a", 32'hC, inst_of(32'hC), 1'b1);
    tick(); chk_out("s5_b", 32'hC, 32'h0, 1'b0); chk_req("s5_b", 1'b1, 32'h10);
    branch_flag_i = 1'b1; branch_target_i = 32'h200;
    tick(); branch_flag_i = 1'b0;
    chk_out("s5_c", 32'hC, 32'h0, 1'b0); chk_req("s5_c", 1'b1, 32'h10);
    tick(); chk_out("s5_d", 32'h10, inst_of(32'h10), 1'b1); chk_req("s5_d", 1'b1, 32'h200);
    tick(); chk_out("s5_e", 32'h200, inst_of(32'h200), 1'b1);
    tick(); chk_out("s5_f", 32'h204, inst_of(32'h204), 1'b1);

    // branch on an ack edge with valid output, then PC wrap at the top of memory
    branch_flag_i = 1'b1; branch_target_i = 32'hFFFF_FFF8;
    tick(); branch_flag_i = 1'b0;
    chk_out("wr_a", 32'h204, 32'h0, 1'b0); chk_req("wr_a", 1'b1, 32'hFFFF_FFF8);
    tick(); chk_out("wr_b", 32'hFFFF_FFF8, inst_of(32'hFFFF_FFF8), 1'b1);
    tick(); chk_out("wr_c", 32'hFFFF_FFFC, inst_of(32'hFFFF_FFFC), 1'b1);
    tick(); chk_out("wr_d", 32'h0, inst_of(32'h0), 1'b1);
    check("wr_d_req_pending", {31'b0, imem_req_o}, 32'd1);

    // reset mid-request with a valid output
    do_reset("s6_rst");
    tick(); chk_req("s6_a", 1'b1, 32'h0); chk_out("s6_a", 32'h0, 32'h0, 1'b0);
    tick(); chk_out("s6_b", 32'h0, inst_of(32'h0), 1'b1);

    // random traffic against the stream model
    slow_en = 1'b0; rand_wait = 1'b1;
    do_reset("rst4");
    exp_next = 32'h0; slot_tgt = '0; slot_wait = 1'b0; tgt_next = 1'b1; armed = 1'b0;
    deliveries = 0; idle = 0; max_idle = 0;
    for (int c = 0; c < 4000; c++) begin
      stall_i       = ($urandom_range(0, 3) == 0);
      branch_flag_i = 1'b0;
      if (armed && $urandom_range(0, 7) == 0) begin
        branch_flag_i   = 1'b1;
        branch_target_i = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'h0000_FFFC);
      end
      tick();
      if (pre_branch) begin
        armed = 1'b0;
        if (pre_valid) begin
          exp_next = pre_tgt;
          tgt_next = 1'b1;
        end else begin
          slot_wait = 1'b1;
          slot_tgt  = pre_tgt;
        end
      end
      if (pre_valid && pre_stall) begin
        check("rnd_hold_pc", if_pc_o, pre_pc);
        check("rnd_hold_inst", if_inst_o, pre_inst);
        check("rnd_hold_valid", {31'b0, if_valid_o}, 32'd1);
      end else if (if_valid_o) begin
        check("rnd_pc", if_pc_o, exp_next);
        check("rnd_inst", if_inst_o, inst_of(exp_next));
        deliveries++;
        idle = 0;
        if (tgt_next) begin
          armed    = 1'b1;
          tgt_next = 1'b0;
        end
        if (slot_wait) begin
          exp_next  = slot_tgt;
          slot_wait = 1'b0;
          tgt_next  = 1'b1;
        end else begin
          exp_next = exp_next + 32'd4;
        end
      end else begin
        check("rnd_bubble_inst", if_inst_o, 32'h0);
        check("rnd_bubble_pc", if_pc_o, pre_pc);
        idle++;
        if (idle > max_idle) max_idle = idle;
      end
    end
    branch_flag_i = 1'b0;
    stall_i       = 1'b0;
    check("rnd_max_idle_ok", {31'b0, max_idle <= 40}, 32'd1);
    check("rnd_deliveries_ok", {31'b0, deliveries >= 500}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
